// File: rtl/alu_key_sequencer_if.sv
// Key/switch inputs and strobed nibble outputs of the ALU key sequencer.
// The slave side is the sequencer itself; the master side is whatever drives the board inputs.
interface alu_key_sequencer_if;
    logic       key_n;
    logic [3:0] sw;
    logic [3:0] Datain;
    logic       readNext;
    logic [1:0] nib_idx;
    logic       frame_done;
    logic       busy;

    modport slave (
        input  key_n,
        input  sw,
        output Datain,
        output readNext,
        output nib_idx,
        output frame_done,
        output busy
    );

    modport master (
        output key_n,
        output sw,
        input  Datain,
        input  readNext,
        input  nib_idx,
        input  frame_done,
        input  busy
    );
endinterface

// File: rtl/alu_key_sequencer.sv
// Debounces an active-low pushbutton and emits one-cycle nibble strobes with frame tracking.
// Define ALU_KEY_SYNC_EN to add 2-flop synchronisers on key_n and sw (adds 2 cycles of latency).
module alu_key_sequencer #(
    parameter int DEBOUNCE_CYCLES   = 250000,
    parameter int NIBBLES_PER_FRAME = 3,
    parameter int CNT_W             = 18
) (
    input  logic                 clk,
    input  logic                 reset,
    alu_key_sequencer_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [1:0]       POS_LAST = 2'(NIBBLES_PER_FRAME - 1);

    state_t           state;
    state_t           stateNext;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cntNext;
    logic             capture;
    logic [1:0]       framePos;
    logic             k;
    logic [3:0]       swSample;

    function automatic logic [1:0] nextPos(input logic [1:0] pos);
        return (pos == POS_LAST) ? 2'd0 : pos + 2'd1;
    endfunction

`ifdef ALU_KEY_SYNC_EN
    logic       keySync_p0;
    logic       keySync_p1;
    logic [3:0] swSync_p0;
    logic [3:0] swSync_p1;

    // Stage p0/p1: synchronisers, reset to "key released, switches low"
    always_ff @(posedge clk) begin
        if (reset) begin
            keySync_p0 <= 1'b1;
            keySync_p1 <= 1'b1;
            swSync_p0  <= 4'd0;
            swSync_p1  <= 4'd0;
        end else begin
            keySync_p0 <= bus.key_n;
            keySync_p1 <= keySync_p0;
            swSync_p0  <= bus.sw;
            swSync_p1  <= swSync_p0;
        end
    end

    assign k        = keySync_p1;
    assign swSample = swSync_p1;
`else
    assign k        = bus.key_n;
    assign swSample = bus.sw;
`endif

    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (!k) begin
                    stateNext = PRESS_WAIT;
                    cntNext   = CNT_ONE;
                end
            end
            PRESS_WAIT: begin
                if (k) begin
                    stateNext = IDLE;
                    cntNext   = '0;
                end else if (cnt == CNT_LAST) begin
                    stateNext = HELD;
                    cntNext   = '0;
                    capture   = 1'b1;
                end else begin
                    cntNext = cnt + CNT_ONE;
                end
            end
            HELD: begin
                if (k) begin
                    stateNext = RELEASE_WAIT;
                    cntNext   = CNT_ONE;
                end
            end
            RELEASE_WAIT: begin
                if (!k) begin
                    stateNext = HELD;
                    cntNext   = '0;
                end else if (cnt == CNT_LAST) begin
                    stateNext = IDLE;
                    cntNext   = '0;
                end else begin
                    cntNext = cnt + CNT_ONE;
                end
            end
            default: begin
                stateNext = HELD;
                cntNext   = '0;
            end
        endcase
    end

    // Resetting into HELD forces a key held through reset to be released before it can fire
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= HELD;
            cnt            <= '0;
            framePos       <= 2'd0;
            bus.Datain     <= 4'd0;
            bus.readNext   <= 1'b0;
            bus.nib_idx    <= 2'd0;
            bus.frame_done <= 1'b0;
        end else begin
            state          <= stateNext;
            cnt            <= cntNext;
            bus.readNext   <= capture;
            bus.frame_done <= capture && (framePos == POS_LAST);
            if (capture) begin
                bus.Datain  <= swSample;
                bus.nib_idx <= framePos;
                framePos    <= nextPos(framePos);
            end
        end
    end

    assign bus.busy = (state != IDLE);

endmodule
